// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state encoding and priority helper for the display scheduler
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam int         NREQ      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    // Isolates the lowest set bit, which is the highest-priority requester.
    function automatic logic [NREQ-1:0] pick_first(input logic [NREQ-1:0] r);
        return r & (~r + NREQ'(1));
    endfunction

endpackage

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - scan prescaler and 2-bit digit index for display multiplexing
module digit_scanner #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] digit,
    output logic       wrap
);

    localparam int PW = $clog2(SCAN_DIV + 1);

    logic [PW-1:0] presc;

    assign wrap = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= 2'd0;
        end else if (wrap) begin
            presc <= '0;
            digit <= digit + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/number_to_7seg.sv
// rtl/number_to_7seg.sv - 0..255 to four active-low 7-segment digits, thousands blank
module number_to_7seg (
    input  logic [7:0]  value,
    output logic [27:0] code
);

    function automatic logic [6:0] digit_seg(input logic [7:0] d);
        case (d)
            8'd0:    digit_seg = 7'h40;
            8'd1:    digit_seg = 7'h79;
            8'd2:    digit_seg = 7'h24;
            8'd3:    digit_seg = 7'h30;
            8'd4:    digit_seg = 7'h19;
            8'd5:    digit_seg = 7'h12;
            8'd6:    digit_seg = 7'h02;
            8'd7:    digit_seg = 7'h78;
            8'd8:    digit_seg = 7'h00;
            8'd9:    digit_seg = 7'h10;
            default: digit_seg = 7'h7F;
        endcase
    endfunction

    logic [7:0] hundreds;
    logic [7:0] tens;
    logic [7:0] ones;

    always_comb begin
        hundreds = value / 8'd100;
        tens     = (value / 8'd10) % 8'd10;
        ones     = value % 8'd10;
        code     = {7'h7F, digit_seg(hundreds), digit_seg(tens), digit_seg(ones)};
    end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - fixed-priority, min-hold arbitration of three requesters onto one 4-digit display
module display_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      value0,
    input  logic [7:0]      value1,
    input  logic [7:0]      value2,
    output logic [NREQ-1:0] grant,
    output logic            grant_changed,
    output logic [6:0]      seg,
    output logic [3:0]      an
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            changed_nxt;
    logic            preempt;
    logic [7:0]      sel_value;
    logic [27:0]     code;
    logic [1:0]      digit;

    // Bits below the owner's position are exactly the higher-priority requesters.
    assign preempt = |(req & (grant - NREQ'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            timer         <= '0;
            grant_changed <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            timer         <= timer_nxt;
            grant_changed <= changed_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        timer_nxt   = timer;
        changed_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt   = pick_first(req);
                    timer_nxt   = TW'(HOLD_CYCLES - 1);
                    state_nxt   = ST_HOLD;
                    changed_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer == '0) begin
                    state_nxt = ST_OPEN;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ST_OPEN: begin
                if (!(|(req & grant)) || preempt) begin
                    if (|req) begin
                        grant_nxt   = pick_first(req);
                        timer_nxt   = TW'(HOLD_CYCLES - 1);
                        state_nxt   = ST_HOLD;
                        changed_nxt = 1'b1;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_value = 8'd0;
        if (grant[0])      sel_value = value0;
        else if (grant[1]) sel_value = value1;
        else if (grant[2]) sel_value = value2;
    end

    number_to_7seg u_conv (
        .value (sel_value),
        .code  (code)
    );

    digit_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .digit (digit),
        .wrap  ()
    );

    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= code[7*digit +: 7];
            an  <= ~(4'b0001 << digit);
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
module tb_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [7:0] value0;
    logic [7:0] value1;
    logic [7:0] value2;
    logic [2:0] grant;
    logic       grant_changed;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_123 [4] = '{7'h30, 7'h24, 7'h79, 7'h7F};

    display_scheduler #(
        .SCAN_DIV    (4),
        .HOLD_CYCLES (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .value0        (value0),
        .value1        (value1),
        .value2        (value2),
        .grant         (grant),
        .grant_changed (grant_changed),
        .seg           (seg),
        .an            (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 3'b111;
        value0 = 8'd0;
        value1 = 8'd0;
        value2 = 8'd0;

        // reset with all requests pending
        tick(2);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_gc", 32'(grant_changed), 32'h0);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        tick(1);
        check("rel_grant", 32'(grant), 32'h1);
        check("rel_gc", 32'(grant_changed), 32'h1);
        tick(1);
        check("rel_gc_drop", 32'(grant_changed), 32'h0);
        check("rel_grant_hold", 32'(grant), 32'h1);

        // scan of 123 from requester 2
        do_reset();
        req    = 3'b100;
        value2 = 8'd123;
        tick(1);
        check("scan_grant", 32'(grant), 32'h4);
        check("scan_gc", 32'(grant_changed), 32'h1);
        tick(1);
        check("scan_first_an", 32'(an), 32'hE);
        check("scan_first_seg", 32'(seg), 32'h30);
        tick(3);
        for (int k = 0; k < 20; k++) begin
            int d;
            d = (1 + k / 4) % 4;
            check($sformatf("scan_an_%0d", k), 32'(an), 32'(an_tab[d]));
            check($sformatf("scan_seg_%0d", k), 32'(seg), 32'(seg_123[d]));
            check($sformatf("scan_gc_%0d", k), 32'(grant_changed), 32'h0);
            tick(1);
        end
        check("scan_grant_end", 32'(grant), 32'h4);

        // value0 = 0 shows leading zeros then blank
        do_reset();
        req    = 3'b001;
        value0 = 8'd0;
        tick(2);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("zero_seg_%0d", k), 32'(seg), (k < 11) ? 32'h40 : 32'h7F);
            tick(1);
        end

        // hold then preempt by requester 0
        do_reset();
        req = 3'b100;
        tick(1);
        check("pre_grant", 32'(grant), 32'h4);
        tick(2);
        req = 3'b101;
        for (int e = 4; e <= 11; e++) begin
            tick(1);
            check($sformatf("pre_hold_grant_%0d", e), 32'(grant), 32'h4);
            check($sformatf("pre_hold_gc_%0d", e), 32'(grant_changed), 32'h0);
        end
        tick(1);
        check("pre_new_grant", 32'(grant), 32'h1);
        check("pre_new_gc", 32'(grant_changed), 32'h1);
        tick(1);
        check("pre_after_grant", 32'(grant), 32'h1);
        check("pre_after_gc", 32'(grant_changed), 32'h0);

        // simultaneous requests, lower-priority contender never wins
        do_reset();
        req = 3'b110;
        tick(1);
        check("sim_grant", 32'(grant), 32'h2);
        check("sim_gc", 32'(grant_changed), 32'h1);
        for (int e = 2; e <= 14; e++) begin
            tick(1);
            check($sformatf("sim_grant_%0d", e), 32'(grant), 32'h2);
            check($sformatf("sim_gc_%0d", e), 32'(grant_changed), 32'h0);
        end

        // owner drops during hold, release to idle after expiry
        do_reset();
        req = 3'b001;
        tick(1);
        check("idle_grant", 32'(grant), 32'h1);
        req = 3'b000;
        for (int e = 2; e <= 11; e++) begin
            tick(1);
            check($sformatf("idle_hold_grant_%0d", e), 32'(grant), 32'h1);
        end
        tick(1);
        check("idle_grant_off", 32'(grant), 32'h0);
        check("idle_gc", 32'(grant_changed), 32'h0);
        tick(1);
        check("idle_an", 32'(an), 32'hF);
        check("idle_seg", 32'(seg), 32'h7F);

        // reset in the middle of a hold
        do_reset();
        req = 3'b010;
        tick(4);
        check("mid_grant", 32'(grant), 32'h2);
        rst_n = 1'b0;
        req   = 3'b000;
        tick(1);
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_gc", 32'(grant_changed), 32'h0);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check($sformatf("mid_idle_grant_%0d", k), 32'(grant), 32'h0);
            check($sformatf("mid_idle_an_%0d", k), 32'(an), 32'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
